// File: rtl/timer_bank_pkg.sv
// Shared register-map constants, CTRL bit positions and channel state encoding
// for the timer_bank compare-timer peripheral.
package timer_bank_pkg;

  localparam logic [31:0] OFF_CYCLE   = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_ACK     = 32'h08;
  localparam logic [31:0] OFF_CH_BASE = 32'h10;
  localparam logic [31:0] CH_STRIDE   = 32'h10;

  // Offsets inside one channel's 16-byte block
  localparam logic [31:0] OFF_COMPARE = 32'h0;
  localparam logic [31:0] OFF_PERIOD  = 32'h4;
  localparam logic [31:0] OFF_CTRL    = 32'h8;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  // Encoding is {pending, en}
  typedef enum logic [1:0] {
    CH_IDLE          = 2'b00,
    CH_ARMED         = 2'b01,
    CH_PENDING_IDLE  = 2'b10,
    CH_PENDING_ARMED = 2'b11
  } ch_state_e;

  // First byte address past the register window (33 bits so it cannot overflow)
  function automatic logic [32:0] window_end(input logic [31:0] base, input int num_ch);
    return {1'b0, base} + {1'b0, OFF_CH_BASE} + {1'b0, CH_STRIDE} * 33'(num_ch);
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Data-memory side bus of the timer bank: address/data/strobes from the CPU,
// combinational load data and address-hit flag back.
interface timer_bank_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        timer_address;

  modport master (
    output address, wdata, mem_read, mem_write,
    input  rdata, timer_address
  );

  modport slave (
    input  address, wdata, mem_read, mem_write,
    output rdata, timer_address
  );
endinterface

// File: rtl/timer_bank_channel.sv
// One compare channel: COMPARE/PERIOD/CTRL registers, pending flag and the
// fire / reload / one-shot logic against the shared cycle counter.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we_compare,
  input  logic             we_period,
  input  logic             we_ctrl,
  input  logic             ack,
  input  logic [3:0]       rd_off,
  output logic [31:0]      rdata,
  output logic             pending,
  output logic             irq
);

  logic [WIDTH-1:0] compare_q, compare_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ie_q, ie_d;
  ch_state_e        state_q, state_d;

  logic en_q, pend_q, fire, en_n, pend_n;
  logic [31:0] ctrl_rd;

  assign en_q   = (state_q == CH_ARMED) || (state_q == CH_PENDING_ARMED);
  assign pend_q = (state_q == CH_PENDING_IDLE) || (state_q == CH_PENDING_ARMED);
  assign fire   = en_q && (cycle == compare_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_q <= '1;
      period_q  <= '0;
      ie_q      <= 1'b0;
      state_q   <= CH_IDLE;
    end else begin
      compare_q <= compare_d;
      period_q  <= period_d;
      ie_q      <= ie_d;
      state_q   <= state_d;
    end
  end

  // Bus writes are applied after the fire update so a written value always wins.
  always_comb begin
    compare_d = compare_q;
    period_d  = period_q;
    ie_d      = ie_q;
    en_n      = en_q;
    pend_n    = pend_q;
    state_d   = state_q;

    if (fire) begin
      pend_n = 1'b1;
      if (period_q != '0) compare_d = compare_q + period_q;
      else                en_n      = 1'b0;
    end
    if (ack && !fire) pend_n = 1'b0;

    if (we_compare) compare_d = wdata;
    if (we_period)  period_d  = wdata;
    if (we_ctrl) begin
      en_n = wdata[CTRL_EN];
      ie_d = wdata[CTRL_IE];
    end

    case ({pend_n, en_n})
      2'b00:   state_d = CH_IDLE;
      2'b01:   state_d = CH_ARMED;
      2'b10:   state_d = CH_PENDING_IDLE;
      default: state_d = CH_PENDING_ARMED;
    endcase
  end

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_IE] = ie_q;
    rdata            = '0;
    if (rd_off == OFF_COMPARE[3:0])     rdata = 32'(compare_q);
    else if (rd_off == OFF_PERIOD[3:0]) rdata = 32'(period_q);
    else if (rd_off == OFF_CTRL[3:0])   rdata = ctrl_rd;
  end

  assign pending = pend_q;
  assign irq     = pend_q & ie_q;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH compare timers sharing one free-running counter;
// sits beside data_mem and raises a level interrupt into cp0.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          WIDTH  = 32,
  parameter logic [31:0] BASE   = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              reset,
  timer_bank_if.slave       bus,
  output logic              timer_interrupt,
  output logic [NUM_CH-1:0] irq_vector
);

  localparam logic [32:0] WIN_END = window_end(BASE, NUM_CH);

  logic [WIDTH-1:0]  cycle_q, cycle_d;
  logic [31:0]       off;
  logic              hit, wr, glob, ack_wr;
  logic [NUM_CH-1:0] pending_vec;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rdata_c;
  logic              unused_wdata;

  assign cycle_d = cycle_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign off    = bus.address - BASE;
  assign hit    = (bus.address >= BASE) && ({1'b0, bus.address} < WIN_END)
                  && (bus.address[1:0] == 2'b00);
  assign wr     = hit && bus.mem_write;
  assign glob   = (off[31:4] == 28'd0);
  assign ack_wr = wr && (off == OFF_ACK);

  // Upper store-data bits are dropped when WIDTH < 32
  assign unused_wdata = ^bus.wdata;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel;
      assign sel = wr && (off[7:4] == 4'(gi + 1));

      timer_channel #(.WIDTH(WIDTH)) u_ch (
        .clk        (clk),
        .reset      (reset),
        .cycle      (cycle_q),
        .wdata      (bus.wdata[WIDTH-1:0]),
        .we_compare (sel && (off[3:0] == OFF_COMPARE[3:0])),
        .we_period  (sel && (off[3:0] == OFF_PERIOD[3:0])),
        .we_ctrl    (sel && (off[3:0] == OFF_CTRL[3:0])),
        .ack        (ack_wr && bus.wdata[gi]),
        .rd_off     (off[3:0]),
        .rdata      (ch_rdata[gi]),
        .pending    (pending_vec[gi]),
        .irq        (irq_vector[gi])
      );
    end
  endgenerate

  always_comb begin
    rdata_c = '0;
    if (bus.mem_read && hit) begin
      if (glob) begin
        if (off == OFF_CYCLE)       rdata_c = 32'(cycle_q);
        else if (off == OFF_STATUS) rdata_c = 32'(pending_vec);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (off[7:4] == 4'(i + 1)) rdata_c = ch_rdata[i];
        end
      end
    end
  end

  assign bus.rdata         = rdata_c;
  assign bus.timer_address = hit;
  assign timer_interrupt   = |irq_vector;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random register
// traffic compared against a register-level behavioural model.
module tb_timer_bank;

  localparam logic [31:0] BASE = 32'hFFFF0000;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timer_bank_if bus ();
  timer_bank_if bus8 ();
  logic           timer_interrupt, timer_interrupt8;
  logic [NCH-1:0] irq_vector, irq_vector8;

  timer_bank #(.NUM_CH(NCH), .WIDTH(32), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .timer_interrupt(timer_interrupt), .irq_vector(irq_vector)
  );

  timer_bank #(.NUM_CH(NCH), .WIDTH(8), .BASE(BASE)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8),
    .timer_interrupt(timer_interrupt8), .irq_vector(irq_vector8)
  );

  int errors = 0;
  int checks = 0;

  // Register-level model of the 32-bit instance
  logic [31:0] m_cycle;
  logic [31:0] m_cmp [NCH];
  logic [31:0] m_per [NCH];
  bit          m_en  [NCH];
  bit          m_ie  [NCH];
  bit          m_pend[NCH];

  function automatic bit model_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h10 + 32'h10 * NCH) && (a % 4 == 0);
  endfunction

  function automatic logic [NCH-1:0] model_irqv();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = m_pend[c] & m_ie[c];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    logic [31:0] st = '0;
    int ch;
    if (!model_hit(a)) return 32'd0;
    off = a - BASE;
    if (off == 0) return m_cycle;
    if (off == 4) begin
      for (int c = 0; c < NCH; c++) st[c] = m_pend[c];
      return st;
    end
    if (off < 32'h10) return 32'd0;
    ch = int'(off / 16) - 1;
    case (off % 16)
      0: return m_cmp[ch];
      4: return m_per[ch];
      8: return {30'd0, m_ie[ch], m_en[ch]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_cycle = 0;
    for (int c = 0; c < NCH; c++) begin
      m_cmp[c] = 32'hFFFFFFFF; m_per[c] = 0; m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
    end
  endtask

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit fire[NCH];
    logic [31:0] off;
    int ch;
    off = a - BASE;
    for (int c = 0; c < NCH; c++) fire[c] = m_en[c] && (m_cycle == m_cmp[c]);
    for (int c = 0; c < NCH; c++) begin
      if (fire[c]) begin
        if (m_per[c] != 0) m_cmp[c] = m_cmp[c] + m_per[c];
        else               m_en[c]  = 0;
      end
    end
    if (we && model_hit(a)) begin
      if (off == 8) begin
        for (int c = 0; c < NCH; c++) if (d[c] && !fire[c]) m_pend[c] = 0;
      end else if (off >= 16) begin
        ch = int'(off / 16) - 1;
        case (off % 16)
          0: m_cmp[ch] = d;
          4: m_per[ch] = d;
          8: begin m_en[ch] = d[0]; m_ie[ch] = d[1]; end
          default: ;
        endcase
      end
    end
    for (int c = 0; c < NCH; c++) if (fire[c]) m_pend[c] = 1;
    m_cycle = m_cycle + 1;
  endtask

  // Called from the negedge phase; returns at the next negedge.
  task automatic step(input bit to8, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (to8) begin
      bus8.address = a; bus8.wdata = d; bus8.mem_write = we;
    end else begin
      bus.address = a; bus.wdata = d; bus.mem_write = we;
    end
    if (we) $display("%0t wr%s addr=%h data=%h", $time, to8 ? "8" : "", a, d);
    @(posedge clk);
    model_edge(we && !to8, a, d);
    @(negedge clk);
    bus.mem_write = 1'b0; bus8.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    step(1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic rd(input bit to8, input logic [31:0] a, output logic [31:0] data, output logic hit);
    if (to8) begin bus8.address = a; bus8.mem_read = 1'b1; end
    else     begin bus.address  = a; bus.mem_read  = 1'b1; end
    #1;
    data = to8 ? bus8.rdata : bus.rdata;
    hit  = to8 ? bus8.timer_address : bus.timer_address;
    bus.mem_read = 1'b0; bus8.mem_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_until(input logic [31:0] c);
    while (m_cycle != c) idle(1);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    #1;
    checks++;
    if (timer_interrupt !== 1'b0 || irq_vector !== '0) begin
      errors++; $display("FAIL reset_irq: got %b/%b required 0/0", timer_interrupt, irq_vector);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; model_reset();
    rd(0, BASE + 32'h4, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 0", d); end
    rd(0, BASE + 32'h10, d, h);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_compare: got %h required ffffffff", d); end
    rd(0, BASE + 32'h34, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_period: got %h required 0", d); end
    idle(10);
    rd(0, BASE, d, h);
    checks++; if (d !== 32'd10 || h !== 1'b1) begin errors++; $display("FAIL cycle_at_10: got %0d hit %b required 10 hit 1", d, h); end
    rd(0, BASE - 32'h4, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL below_base: got %h hit %b required 0 hit 0", d, h); end
    rd(0, BASE + 32'hC, d, h);
    checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL unused_offset: got %h hit %b required 0 hit 1", d, h); end
    rd(0, BASE + 32'h50, d, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL past_window: got hit %b required 0", h); end
    rd(0, BASE + 32'h2, d, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL misaligned: got hit %b required 0", h); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic h; bit seen = 0;
    do_reset();
    wr(32'h10, 32'd50);
    wr(32'h18, 32'd3);
    for (int i = 0; i < 100; i++) begin
      if (timer_interrupt === 1'b1) begin seen = 1; break; end
      idle(1);
    end
    checks++; if (!seen) begin errors++; $display("FAIL oneshot_timeout: got no interrupt required one"); end
    rd(0, BASE, d, h);
    checks++; if (d !== 32'd51) begin errors++; $display("FAIL oneshot_rise_cycle: got %0d required 51", d); end
    rd(0, BASE + 32'h4, d, h);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h required 1", d); end
    rd(0, BASE + 32'h18, d, h);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL oneshot_ctrl: got %h required 2", d); end
    checks++; if (irq_vector !== 4'b0001) begin errors++; $display("FAIL oneshot_vector: got %b required 0001", irq_vector); end
    wr(32'h8, 32'h1);
    checks++; if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL oneshot_ack: got %b required 0", timer_interrupt); end
  endtask

  task automatic test_periodic();
    logic [31:0] d; logic h; bit seen;
    do_reset();
    wr(32'h20, 32'd20);
    wr(32'h24, 32'd7);
    wr(32'h28, 32'd3);
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        if (timer_interrupt === 1'b1) begin seen = 1; break; end
        idle(1);
      end
      rd(0, BASE, d, h);
      checks++;
      if (!seen || d - 1 !== 32'(20 + 7 * k)) begin
        errors++; $display("FAIL periodic_fire%0d: got cycle %0d seen %b required %0d", k, d - 1, seen, 20 + 7 * k);
      end
      wr(32'h8, 32'h2);
    end
    rd(0, BASE + 32'h20, d, h);
    checks++; if (d !== 32'd41) begin errors++; $display("FAIL periodic_compare: got %0d required 41", d); end
  endtask

  task automatic test_collisions();
    logic [31:0] d; logic h;
    do_reset();
    wr(32'h30, 32'd30); wr(32'h38, 32'd3);
    wr(32'h40, 32'd40); wr(32'h48, 32'd3);
    wr(32'h20, 32'd45); wr(32'h24, 32'd5); wr(32'h28, 32'd3);
    wr(32'h10, 32'd55); wr(32'h18, 32'd3);
    run_until(32'd30);
    wr(32'h8, 32'h4);
    rd(0, BASE + 32'h4, d, h);
    checks++; if (d[2] !== 1'b1 || irq_vector[2] !== 1'b1) begin errors++; $display("FAIL ack_vs_fire: got status %h vec %b required bit2 set", d, irq_vector); end
    run_until(32'd40);
    wr(32'h40, 32'h1234);
    rd(0, BASE + 32'h40, d, h);
    checks++; if (d !== 32'h1234) begin errors++; $display("FAIL compare_vs_fire: got %h required 1234", d); end
    rd(0, BASE + 32'h48, d, h);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL compare_vs_fire_ctrl: got %h required 2", d); end
    run_until(32'd45);
    wr(32'h24, 32'd9);
    rd(0, BASE + 32'h20, d, h);
    checks++; if (d !== 32'd50) begin errors++; $display("FAIL period_vs_fire_compare: got %0d required 50", d); end
    rd(0, BASE + 32'h24, d, h);
    checks++; if (d !== 32'd9) begin errors++; $display("FAIL period_vs_fire_period: got %0d required 9", d); end
    run_until(32'd55);
    wr(32'h18, 32'h1);
    rd(0, BASE + 32'h18, d, h);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_vs_fire: got %h required 1", d); end
    rd(0, BASE + 32'h4, d, h);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL collisions_status: got %h required f", d); end
    checks++; if (irq_vector !== 4'b1110 || timer_interrupt !== 1'b1) begin errors++; $display("FAIL ie_mask: got %b/%b required 1110/1", irq_vector, timer_interrupt); end
  endtask

  task automatic test_random();
    logic [31:0] d, a, v, exp; logic h; int k, ch;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      ch = $urandom_range(0, NCH - 1);
      case ($urandom_range(0, 9))
        0, 1: wr(32'h10 + 32'h10 * ch, m_cycle + $urandom_range(2, 40));
        2:    wr(32'h14 + 32'h10 * ch, $urandom_range(0, 12));
        3:    wr(32'h18 + 32'h10 * ch, $urandom);
        4:    wr(32'h8, $urandom);
        5:    begin
                k = $urandom_range(0, 3);
                v = (k == 0) ? 32'h0 : (k == 1) ? 32'h4 : (k == 2) ? 32'hC : 32'h1C + 32'h10 * ch;
                wr(v, $urandom);
              end
        6:    step(1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? BASE - 32'h4 : BASE + 32'h50, $urandom);
        default: idle(1);
      endcase
      k = $urandom_range(0, 23);
      a = (k < 20) ? BASE + 32'(4 * k) : (k == 20) ? BASE - 32'h4 :
          (k == 21) ? BASE + 32'h50 : (k == 22) ? BASE + 32'h2 : 32'h1000;
      exp = model_read(a);
      rd(0, a, d, h);
      checks++;
      if (d !== exp || h !== model_hit(a)) begin
        errors++; $display("FAIL rand_read %h: got %h hit %b required %h hit %b", a, d, h, exp, model_hit(a));
      end
      checks++;
      if (irq_vector !== model_irqv() || timer_interrupt !== |model_irqv()) begin
        errors++; $display("FAIL rand_irq: got %b/%b required %b/%b", irq_vector, timer_interrupt, model_irqv(), |model_irqv());
      end
    end
    bus.address = BASE; bus.mem_read = 1'b0; #1;
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL no_read_strobe: got %h required 0", bus.rdata); end
  endtask

  task automatic test_width8();
    logic [31:0] d; logic h; bit seen;
    do_reset();
    step(1'b1, 1'b1, BASE + 32'h20, 32'h12345678);
    rd(1, BASE + 32'h20, d, h);
    checks++; if (d !== 32'h78) begin errors++; $display("FAIL w8_truncate: got %h required 78", d); end
    step(1'b1, 1'b1, BASE + 32'h10, 32'd250);
    step(1'b1, 1'b1, BASE + 32'h14, 32'd10);
    step(1'b1, 1'b1, BASE + 32'h18, 32'd3);
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      for (int i = 0; i < 300; i++) begin
        if (timer_interrupt8 === 1'b1) begin seen = 1; break; end
        idle(1);
      end
      rd(1, BASE, d, h);
      checks++;
      if (!seen || d !== ((k == 0) ? 32'd251 : 32'd5)) begin
        errors++; $display("FAIL w8_fire%0d: got cycle %0d seen %b required %0d", k, d, seen, (k == 0) ? 251 : 5);
      end
      step(1'b1, 1'b1, BASE + 32'h8, 32'h1);
    end
    rd(1, BASE + 32'h10, d, h);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL w8_compare: got %0d required 14", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic h;
    do_reset();
    wr(32'h10, 32'd10); wr(32'h18, 32'd3);
    wr(32'h20, 32'd12); wr(32'h28, 32'd3);
    run_until(32'd20);
    checks++; if (irq_vector !== 4'b0011) begin errors++; $display("FAIL pre_reset_vec: got %b required 0011", irq_vector); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (timer_interrupt !== 1'b0 || irq_vector !== '0) begin errors++; $display("FAIL async_reset_irq: got %b/%b required 0/0", timer_interrupt, irq_vector); end
    rd(0, BASE + 32'h4, d, h);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_reset_status: got %h required 0", d); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; model_reset();
    idle(3);
    rd(0, BASE, d, h);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL cycle_restart: got %0d required 3", d); end
  endtask

  initial begin
    bus.address = '0; bus.wdata = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus8.address = '0; bus8.wdata = '0; bus8.mem_read = 1'b0; bus8.mem_write = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_collisions();
    test_random();
    test_width8();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Memory-mapped bank of NUM_CH independent compare timers sharing one free-running cycle counter.
- Supersedes the single-channel timer in the single-cycle MIPS machine and sits on the same data-memory address/data path.
- Adds per-channel auto-reload (periodic) mode, per-channel interrupt masks, a pending-status register and write-1-to-clear acknowledge.
- Drives a level interrupt line into cp0 and an address-hit flag that gates data_mem reads and writes.

Parameters:
- NUM_CH, 4: number of timer channels, 1..8.
- WIDTH, 32: cycle counter, compare and period width, 8..32; zero-extended on the 32-bit read bus.
- BASE, 32'hFFFF0000: byte base address of the register window; 64-byte aligned.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- address  in  32  byte address (ALU output)
- wdata  in  32  store data (rt value)
- mem_read  in  1  load strobe from decode
- mem_write  in  1  store strobe from decode
- rdata  out  32  load data; 0 unless this is a read hit
- timer_address  out  1  combinational hit: BASE <= address < BASE+0x10+0x10*NUM_CH, word aligned
- timer_interrupt  out  1  OR of (pending & ie) over all channels
- irq_vector  out  NUM_CH  per-channel pending & ie

Behaviour:
- Address map, byte offsets from BASE:
  - 0x00 CYCLE: read-only; writes ignored.
  - 0x04 STATUS: pending[NUM_CH-1:0], read-only.
  - 0x08 ACK: write-1-to-clear pending; reads as 0.
  - 0x10+0x10*ch+0x0 COMPARE[ch], R/W.
  - +0x4 PERIOD[ch], R/W; 0 selects one-shot.
  - +0x8 CTRL[ch], R/W: bit0 en, bit1 ie; other bits read 0.
  - Unused offsets inside the window read 0 and ignore writes, but still assert timer_address.
- Reads are combinational (same cycle, single-cycle CPU). rdata = 0 when mem_read=0 or timer_address=0.
- Writes take effect on the rising edge when mem_write and timer_address are both high. Register bits above WIDTH are truncated on write.
- Cycle counter:
  - Increments by 1 every clk.
  - Wraps from 2^WIDTH-1 to 0 with no flag.
- Fire condition, per channel, evaluated on the registered values before the edge: en && cycle == compare. On the edge when a channel fires:
  - pending[ch] <= 1.
  - If PERIOD != 0: compare <= compare + PERIOD mod 2^WIDTH; en stays 1.
  - If PERIOD == 0: en <= 0 (one-shot).
- Per-channel state machine:
  - IDLE (en=0), ARMED (en=1, pending=0), PENDING_ARMED (en=1, pending=1), PENDING_IDLE (en=0, pending=1).
  - Transitions are set by en writes, fire events and ack writes.
- Simultaneous events in one edge:
  - Fire and ACK bit for the same channel: fire wins, pending stays 1.
  - Fire and a COMPARE write: the written value wins, reload is discarded, pending is still set.
  - Fire and a CTRL write: the written CTRL wins (including en), pending is still set.
  - Fire and a PERIOD write: the fire uses the old PERIOD; the new PERIOD is latched.
- Interrupt timing:
  - timer_interrupt and irq_vector are combinational from registered pending/ie.
  - They rise in the cycle after the firing edge and stay high until acked or ie is cleared.
  - Clearing ie masks the output but does not clear pending.
- Reset, asynchronous, valid mid-operation: cycle=0; every compare=all-ones; period=0; en=0; ie=0; pending=0. All outputs deassert immediately.
- A compare already passed is not caught up: the channel fires only after the counter wraps back to it.

Decomposition:
- Shared package timer_bank_pkg holds:
  - Offset constants: OFF_CYCLE, OFF_STATUS, OFF_ACK, OFF_CH_BASE, OFF_COMPARE, OFF_PERIOD, OFF_CTRL.
  - CTRL bit indices: CTRL_EN, CTRL_IE.
  - Channel stride 0x10.
- One sub-module, timer_channel, instantiated NUM_CH times. It holds compare, period, ctrl and pending, takes the shared cycle value, decoded write strobes and the ack bit, and returns its read mux output and irq bit.
- Top level contains the counter, address decode, read mux and interrupt OR.

Test Plan:
- Reset, then read CYCLE at cycle 10 -> rdata=10, timer_address=1. Read address BASE-4 -> timer_address=0, rdata=0.
- Ch0 one-shot: COMPARE=50, CTRL=3 -> timer_interrupt rises in the cycle after CYCLE=50, STATUS=0x1, CTRL reads 0x2. Write ACK=1 -> interrupt falls the next cycle.
- Ch1 periodic: COMPARE=20, PERIOD=7, CTRL=3, ack each fire -> fires at 20, 27, 34. COMPARE reads 41 after the third fire.
- Ch2 ACK on the exact fire edge -> pending remains 1. Ch3 COMPARE write on its fire edge -> COMPARE holds the written value, pending=1.
- WIDTH=8, periodic COMPARE=250, PERIOD=10 -> fires at 250, then at 4 after the counter wraps.
- Assert reset asynchronously mid-cycle with ch0 and ch1 pending -> timer_interrupt, irq_vector and STATUS read 0 immediately. CYCLE restarts at 0 after release.
